// File: rtl/conv_pkg.sv
// Shared load-FSM states and TUSER field layout for the conv accelerator input stage.
package conv_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_W,
        S_B,
        S_X
    } load_state_t;

    localparam int TUSER_NEWW_BIT = 0;
    localparam int TUSER_K_LSB    = 1;

endpackage

// File: rtl/input_mems_multibuf_memory.sv
// Single-port RAM: synchronous write, registered read (1-cycle latency, old data on collision).
module memory #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/input_mems_multibuf.sv
// Input memory stage: W/B/K held once, X held in NBANK ring-ordered banks so the next
// matrix can stream in over AXI-Stream while the MAC datapath reads a loaded bank.
module input_mems_multibuf
    import conv_pkg::*;
#(
    parameter int INW    = 24,
    parameter int R      = 9,
    parameter int C      = 8,
    parameter int MAXK   = 4,
    parameter int NBANK  = 2,
    localparam int K_BITS    = $clog2(MAXK + 1),
    localparam int BANK_BITS = $clog2(NBANK),
    localparam int XA        = $clog2(R * C),
    localparam int WA        = $clog2(MAXK * MAXK)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [INW-1:0]        AXIS_TDATA,
    input  logic                  AXIS_TVALID,
    input  logic [K_BITS:0]       AXIS_TUSER,
    output logic                  AXIS_TREADY,
    output logic                  inputs_loaded,
    input  logic                  compute_finished,
    output logic [BANK_BITS-1:0]  rd_bank,
    output logic [K_BITS-1:0]     K,
    output logic signed [INW-1:0] B,
    input  logic [XA-1:0]         X_read_addr,
    output logic signed [INW-1:0] X_data,
    input  logic [WA-1:0]         W_read_addr,
    output logic signed [INW-1:0] W_data
);

    localparam int KKW = 2 * K_BITS;
    localparam int CW  = (WA > KKW) ? WA : KKW;

    load_state_t state, next_state;

    logic [NBANK-1:0]     full;
    logic [BANK_BITS-1:0] wr_bank;
    logic [WA-1:0]        w_cnt;
    logic [XA-1:0]        x_cnt;
    logic                 tuser_new_w;
    logic [K_BITS-1:0]    tuser_k;
    logic [KKW-1:0]       kk;
    logic [KKW-1:0]       kk_in;
    logic                 ready;
    logic                 accept;
    logic                 release_bank;
    logic                 any_full;
    logic                 w_last;
    logic                 x_last;
    logic                 w_we;
    logic [WA-1:0]        w_addr;
    logic                 x_path;
    logic [INW-1:0]       w_rdata;
    logic [INW-1:0]       x_rdata [NBANK];

    function automatic logic [BANK_BITS-1:0] next_bank(input logic [BANK_BITS-1:0] b);
        return (b == BANK_BITS'(NBANK - 1)) ? '0 : b + BANK_BITS'(1);
    endfunction

    assign tuser_new_w = AXIS_TUSER[TUSER_NEWW_BIT];
    assign tuser_k     = AXIS_TUSER[TUSER_K_LSB +: K_BITS];
    assign kk          = {{K_BITS{1'b0}}, K} * {{K_BITS{1'b0}}, K};
    assign kk_in       = {{K_BITS{1'b0}}, tuser_k} * {{K_BITS{1'b0}}, tuser_k};
    assign any_full    = |full;
    assign w_last      = (CW'(w_cnt) == CW'(kk) - CW'(1));
    assign x_last      = (x_cnt == XA'(R * C - 1));

    assign AXIS_TREADY   = ready;
    assign accept        = AXIS_TVALID && ready;
    assign inputs_loaded = reset_n && full[rd_bank];
    assign release_bank  = compute_finished && inputs_loaded;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // W/B/K are single-buffered, so a new_W transfer waits until every X bank is released.
    always_comb begin
        next_state = state;
        ready      = 1'b0;
        case (state)
            S_IDLE: begin
                ready = !full[wr_bank] && (!tuser_new_w || !any_full);
                if (AXIS_TVALID && ready) begin
                    if (tuser_new_w) begin
                        next_state = (kk_in > KKW'(1)) ? S_W : S_B;
                    end else begin
                        next_state = S_X;
                    end
                end
            end
            S_W: begin
                ready = 1'b1;
                if (AXIS_TVALID && w_last) begin
                    next_state = S_B;
                end
            end
            S_B: begin
                ready = 1'b1;
                if (AXIS_TVALID) begin
                    next_state = S_X;
                end
            end
            S_X: begin
                ready = 1'b1;
                if (AXIS_TVALID && x_last) begin
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
        if (!reset_n) begin
            ready = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            full    <= '0;
            wr_bank <= '0;
            rd_bank <= '0;
            w_cnt   <= '0;
            x_cnt   <= '0;
            K       <= '0;
            B       <= '0;
        end else begin
            if (accept) begin
                case (state)
                    S_IDLE: begin
                        if (tuser_new_w) begin
                            K     <= tuser_k;
                            w_cnt <= (kk_in > KKW'(1)) ? WA'(1) : '0;
                        end else begin
                            x_cnt <= XA'(1);
                        end
                    end
                    S_W: begin
                        w_cnt <= w_last ? '0 : w_cnt + WA'(1);
                    end
                    S_B: begin
                        B <= AXIS_TDATA;
                    end
                    S_X: begin
                        if (x_last) begin
                            x_cnt         <= '0;
                            full[wr_bank] <= 1'b1;
                            wr_bank       <= next_bank(wr_bank);
                        end else begin
                            x_cnt <= x_cnt + XA'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
            // The bank being released is never the bank completing a write on this edge.
            if (release_bank) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= next_bank(rd_bank);
            end
        end
    end

    assign w_we   = accept && ((state == S_IDLE && tuser_new_w) || state == S_W);
    assign w_addr = (state == S_W || (state == S_IDLE && accept)) ? w_cnt : W_read_addr;
    assign x_path = (state == S_X) || (state == S_IDLE && accept && !tuser_new_w);

    memory #(
        .WIDTH(INW),
        .DEPTH(MAXK * MAXK)
    ) u_w_mem (
        .clk   (clk),
        .we    (w_we),
        .addr  (w_addr),
        .wdata (AXIS_TDATA),
        .rdata (w_rdata)
    );

    assign W_data = w_rdata;

    for (genvar b = 0; b < NBANK; b++) begin : g_xbank
        logic sel;
        assign sel = x_path && (wr_bank == BANK_BITS'(b));

        memory #(
            .WIDTH(INW),
            .DEPTH(R * C)
        ) u_x_mem (
            .clk   (clk),
            .we    (sel && accept),
            .addr  (sel ? x_cnt : X_read_addr),
            .wdata (AXIS_TDATA),
            .rdata (x_rdata[b])
        );
    end

    assign X_data = x_rdata[rd_bank];

endmodule

// File: tb/tb_input_mems_multibuf.sv
// Self-checking bench for input_mems_multibuf against a transfer-level model of banks and counts.
module tb_input_mems_multibuf;

    localparam int INW       = 24;
    localparam int R         = 9;
    localparam int C         = 8;
    localparam int MAXK      = 4;
    localparam int NBANK     = 2;
    localparam int K_BITS    = 3;
    localparam int BANK_BITS = 1;
    localparam int XA        = 7;
    localparam int WA        = 4;
    localparam int NX        = R * C;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic [INW-1:0]        AXIS_TDATA = '0;
    logic                  AXIS_TVALID = 1'b0;
    logic [K_BITS:0]       AXIS_TUSER = '0;
    logic                  AXIS_TREADY;
    logic                  inputs_loaded;
    logic                  compute_finished = 1'b0;
    logic [BANK_BITS-1:0]  rd_bank;
    logic [K_BITS-1:0]     K;
    logic signed [INW-1:0] B;
    logic [XA-1:0]         X_read_addr = '0;
    logic signed [INW-1:0] X_data;
    logic [WA-1:0]         W_read_addr = '0;
    logic signed [INW-1:0] W_data;

    always #5 clk = ~clk;

    input_mems_multibuf #(
        .INW(INW), .R(R), .C(C), .MAXK(MAXK), .NBANK(NBANK)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .AXIS_TDATA       (AXIS_TDATA),
        .AXIS_TVALID      (AXIS_TVALID),
        .AXIS_TUSER       (AXIS_TUSER),
        .AXIS_TREADY      (AXIS_TREADY),
        .inputs_loaded    (inputs_loaded),
        .compute_finished (compute_finished),
        .rd_bank          (rd_bank),
        .K                (K),
        .B                (B),
        .X_read_addr      (X_read_addr),
        .X_data           (X_data),
        .W_read_addr      (W_read_addr),
        .W_data           (W_data)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: matrices completed so far land in banks in ring order,
    // and are consumed in the same order.
    logic [INW-1:0] exp_x [NBANK][NX];
    logic [INW-1:0] exp_w [MAXK*MAXK];
    logic [INW-1:0] exp_b = '0;
    int             exp_k = 0;
    int             loaded_cnt = 0;
    int             released_cnt = 0;

    typedef struct {
        int             w_addr;
        int             x_addr;
        logic [INW-1:0] exp_w;
        logic [INW-1:0] exp_x;
    } rd_vec_t;

    rd_vec_t vecs [5];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int w_addr, input int x_addr);
        W_read_addr = WA'(w_addr);
        X_read_addr = XA'(x_addr);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic releaseBank();
        compute_finished = 1'b1;
        @(posedge clk);
        if (loaded_cnt > released_cnt) released_cnt++;
        @(negedge clk);
        compute_finished = 1'b0;
    endtask

    // Offer one word; every waiting cycle checks TREADY, inputs_loaded and rd_bank against the model.
    task automatic sendWord(input logic [INW-1:0] data, input logic [K_BITS:0] user, input int gap_pct,
                            input bit is_first, input bit cf, output bit ok);
        int waited;
        bit exp_rdy;
        ok = 1'b0;
        waited = 0;
        while (int'($urandom_range(99)) < gap_pct) begin
            AXIS_TVALID = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        AXIS_TDATA  = data;
        AXIS_TUSER  = user;
        AXIS_TVALID = 1'b1;
        while (!ok) begin
            #1;
            if (!is_first)    exp_rdy = 1'b1;
            else if (user[0]) exp_rdy = (loaded_cnt == released_cnt);
            else              exp_rdy = (loaded_cnt - released_cnt) < NBANK;
            checkOutput("tready", 32'(AXIS_TREADY), 32'(exp_rdy));
            checkOutput("inputs_loaded", 32'(inputs_loaded), 32'(loaded_cnt > released_cnt));
            checkOutput("rd_bank", 32'(rd_bank), 32'(released_cnt % NBANK));
            if (AXIS_TREADY) begin
                if (cf) compute_finished = 1'b1;
                @(posedge clk);
                if (cf && loaded_cnt > released_cnt) released_cnt++;
                @(negedge clk);
                AXIS_TVALID = 1'b0;
                if (cf) compute_finished = 1'b0;
                ok = 1'b1;
            end else begin
                waited++;
                if (waited > 300) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL tready_timeout: waited %0d cycles, expected acceptance", waited);
                    AXIS_TVALID = 1'b0;
                    return;
                end
                @(posedge clk);
                @(negedge clk);
            end
        end
    endtask

    // Whole transfer; pattern=1 uses fixed W/X values so the readback table can hold constants.
    task automatic sendTransfer(input bit new_w, input int k, input logic [INW-1:0] b_val, input int gap_pct,
                                input bit rel_on_last, input bit pattern, input int stop_after, output bit ok);
        logic [INW-1:0] xs [NX];
        logic [INW-1:0] w;
        logic [K_BITS:0] user;
        bit first;
        user  = {K_BITS'(k), new_w};
        first = 1'b1;
        ok    = 1'b0;
        if (new_w) begin
            for (int i = 0; i < k * k; i++) begin
                w = pattern ? INW'(i * 16 - 40) : INW'($urandom);
                sendWord(w, user, gap_pct, first, 1'b0, ok);
                if (!ok) return;
                if (first) exp_k = k;
                exp_w[i] = w;
                first = 1'b0;
            end
            sendWord(b_val, user, gap_pct, 1'b0, 1'b0, ok);
            if (!ok) return;
            exp_b = b_val;
        end
        for (int i = 0; i < NX; i++) begin
            if (i == stop_after) begin
                ok = 1'b0;
                return;
            end
            xs[i] = pattern ? INW'(i * 1000 + 7) : INW'($urandom);
            sendWord(xs[i], user, gap_pct, first, rel_on_last && (i == NX - 1), ok);
            if (!ok) return;
            first = 1'b0;
        end
        exp_x[loaded_cnt % NBANK] = xs;
        loaded_cnt++;
    endtask

    task automatic readRandomX(input int n, input string name);
        int a;
        for (int j = 0; j < n; j++) begin
            a = int'($urandom_range(NX - 1));
            if (j == 0) a = NX - 1;
            applyStimulus(0, a);
            checkOutput(name, 32'($unsigned(X_data)), 32'(exp_x[released_cnt % NBANK][a]));
        end
    endtask

    task automatic checkResetValues();
        checkOutput("rst_tready", 32'(AXIS_TREADY), 32'(0));
        checkOutput("rst_inputs_loaded", 32'(inputs_loaded), 32'(0));
        checkOutput("rst_rd_bank", 32'(rd_bank), 32'(0));
        checkOutput("rst_K", 32'(K), 32'(0));
        checkOutput("rst_B", 32'($unsigned(B)), 32'(0));
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit ok;

        vecs[0] = '{0, 0,  24'hFFFFD8, 24'd7};
        vecs[1] = '{1, 1,  24'hFFFFE8, 24'd1007};
        vecs[2] = '{4, 35, 24'd24,     24'd35007};
        vecs[3] = '{7, 70, 24'd72,     24'd70007};
        vecs[4] = '{8, 71, 24'd88,     24'd71007};

        // Reset state, with TVALID offered to confirm TREADY is held low.
        AXIS_TVALID = 1'b1;
        AXIS_TUSER  = {3'd3, 1'b1};
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkResetValues();
        AXIS_TVALID = 1'b0;
        reset_n = 1'b1;

        // K=3 full load with fixed data, then table-driven readback.
        sendTransfer(1'b1, 3, -24'sd5, 0, 1'b0, 1'b1, -1, ok);
        checkOutput("loaded_after_first", 32'(inputs_loaded), 32'(1));
        checkOutput("K_first", 32'(K), 32'(3));
        checkOutput("B_first", 32'($unsigned(B)), 32'(24'hFFFFFB));
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].w_addr, vecs[i].x_addr);
            checkOutput($sformatf("W_tab%0d", i), 32'($unsigned(W_data)), 32'(vecs[i].exp_w));
            checkOutput($sformatf("X_tab%0d", i), 32'($unsigned(X_data)), 32'(vecs[i].exp_x));
        end

        // Second matrix into bank1 while bank0 is still in use.
        sendTransfer(1'b0, 0, '0, 0, 1'b0, 1'b0, -1, ok);
        checkOutput("rd_bank_still0", 32'(rd_bank), 32'(0));
        checkOutput("loaded_both", 32'(inputs_loaded), 32'(1));

        // Both banks full: third transfer stalls until a release, then lands in bank0.
        fork
            sendTransfer(1'b0, 0, '0, 0, 1'b0, 1'b0, -1, ok);
            begin
                repeat (5) @(negedge clk);
                releaseBank();
            end
        join
        checkOutput("rd_bank_after_rel", 32'(rd_bank), 32'(1));
        readRandomX(4, "X_bank1");

        // new_W with K=2 waits until every bank has been released.
        fork
            sendTransfer(1'b1, 2, 24'd123, 0, 1'b0, 1'b0, -1, ok);
            begin
                repeat (4) @(negedge clk);
                for (int n = 0; n < 4 && loaded_cnt > released_cnt; n++) begin
                    releaseBank();
                    repeat (2) @(negedge clk);
                end
            end
        join
        checkOutput("K_second", 32'(K), 32'(exp_k));
        checkOutput("B_second", 32'($unsigned(B)), 32'(exp_b));
        for (int i = 0; i < 4; i++) begin
            applyStimulus(i, 0);
            checkOutput($sformatf("W_k2_%0d", i), 32'($unsigned(W_data)), 32'(exp_w[i]));
        end
        readRandomX(3, "X_k2");

        // 30% TVALID gaps; last X word and a release share one edge.
        sendTransfer(1'b0, 0, '0, 30, 1'b1, 1'b0, -1, ok);
        checkOutput("loaded_after_overlap", 32'(inputs_loaded), 32'(loaded_cnt > released_cnt));
        checkOutput("rd_bank_after_overlap", 32'(rd_bank), 32'(released_cnt % NBANK));
        readRandomX(4, "X_gap_a");
        sendTransfer(1'b0, 0, '0, 30, 1'b0, 1'b0, -1, ok);
        AXIS_TUSER = '0;
        #1;
        checkOutput("tready_full_x", 32'(AXIS_TREADY), 32'(0));
        AXIS_TUSER = {3'd2, 1'b1};
        #1;
        checkOutput("tready_full_w", 32'(AXIS_TREADY), 32'(0));
        @(negedge clk);
        releaseBank();
        checkOutput("loaded_after_rel1", 32'(inputs_loaded), 32'(1));
        readRandomX(4, "X_gap_b");
        releaseBank();
        checkOutput("loaded_after_rel2", 32'(inputs_loaded), 32'(0));

        // Reset in the middle of an X transfer, then a fresh load into bank0.
        sendTransfer(1'b0, 0, '0, 0, 1'b0, 1'b0, 40, ok);
        AXIS_TVALID = 1'b1;
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkResetValues();
        AXIS_TVALID  = 1'b0;
        loaded_cnt   = 0;
        released_cnt = 0;
        exp_k        = 0;
        exp_b        = '0;
        reset_n      = 1'b1;
        sendTransfer(1'b1, 3, 24'h000321, 0, 1'b0, 1'b0, -1, ok);
        checkOutput("rd_bank_after_reset_load", 32'(rd_bank), 32'(0));
        checkOutput("loaded_after_reset_load", 32'(inputs_loaded), 32'(1));
        checkOutput("K_after_reset_load", 32'(K), 32'(3));
        checkOutput("B_after_reset_load", 32'($unsigned(B)), 32'(24'h000321));
        applyStimulus(8, 0);
        checkOutput("W8_after_reset_load", 32'($unsigned(W_data)), 32'(exp_w[8]));
        checkOutput("X0_after_reset_load", 32'($unsigned(X_data)), 32'(exp_x[0][0]));
        readRandomX(4, "X_after_reset_load");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
